// File: rtl/johnson_monitor.sv
// Johnson-code phase monitor: decodes a 4-bit Johnson count, checks step order, counts revolutions.
// Define JOHNSON_MONITOR_ERRCNT_EN to add the saturating err_cnt output.
module johnson_monitor (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] q_in,
    input  logic       en,
    input  logic       clr_err,
    output logic [2:0] phase,
    output logic [7:0] phase_oh,
    output logic       valid,
    output logic       illegal,
    output logic       seq_err,
    output logic       rev_tick,
    output logic [7:0] rev_cnt,
`ifdef JOHNSON_MONITOR_ERRCNT_EN
    output logic [7:0] err_cnt,
`endif
    output logic       err_sticky
);

    localparam int unsigned PHASE_W = 3;
    localparam int unsigned OH_W    = 8;
    localparam int unsigned CNT_W   = 8;

    typedef enum logic [1:0] {ACQUIRE, TRACK, FAULT} state_t;

    state_t               state, state_d;
    logic                 code_ok;
    logic [PHASE_W-1:0]   code_ph;
    logic [PHASE_W-1:0]   phase_d;
    logic [OH_W-1:0]      phase_oh_d;
    logic                 valid_d, illegal_d, seq_err_d, rev_tick_d, err_sticky_d, err_now;
    logic [CNT_W-1:0]     rev_cnt_d;
`ifdef JOHNSON_MONITOR_ERRCNT_EN
    logic [CNT_W-1:0]     err_cnt_d, err_cnt_base;
`endif

    // Johnson code to phase index
    always_comb begin
        code_ok = 1'b1;
        code_ph = '0;
        case (q_in)
            4'b0000: code_ph = PHASE_W'(0);
            4'b1000: code_ph = PHASE_W'(1);
            4'b1100: code_ph = PHASE_W'(2);
            4'b1110: code_ph = PHASE_W'(3);
            4'b1111: code_ph = PHASE_W'(4);
            4'b0111: code_ph = PHASE_W'(5);
            4'b0011: code_ph = PHASE_W'(6);
            4'b0001: code_ph = PHASE_W'(7);
            default: code_ok = 1'b0;
        endcase
    end

    // Next state and next register values; a new error overrides clr_err
    always_comb begin
        state_d      = state;
        phase_d      = phase;
        rev_cnt_d    = rev_cnt;
        err_sticky_d = err_sticky;
        illegal_d    = 1'b0;
        seq_err_d    = 1'b0;
        rev_tick_d   = 1'b0;

        if (en) begin
            case (state)
                ACQUIRE: begin
                    if (code_ok) begin
                        phase_d = code_ph;
                        state_d = TRACK;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
                TRACK: begin
                    if (!code_ok) begin
                        illegal_d = 1'b1;
                    end else if (code_ph == PHASE_W'(phase + PHASE_W'(1))) begin
                        phase_d = code_ph;
                        if (phase == PHASE_W'(7)) begin
                            rev_tick_d = 1'b1;
                            rev_cnt_d  = CNT_W'(rev_cnt + CNT_W'(1));
                        end
                    end else if (code_ph != phase) begin
                        seq_err_d = 1'b1;
                    end
                end
                default: begin
                    illegal_d = !code_ok;
                end
            endcase
        end

        err_now = illegal_d | seq_err_d;
        if (clr_err) begin
            err_sticky_d = 1'b0;
            if (state == FAULT) state_d = ACQUIRE;
        end
        if (err_now) begin
            err_sticky_d = 1'b1;
            state_d      = FAULT;
        end

        valid_d    = (state_d == TRACK);
        phase_oh_d = valid_d ? OH_W'(OH_W'(1) << phase_d) : '0;

`ifdef JOHNSON_MONITOR_ERRCNT_EN
        err_cnt_base = clr_err ? '0 : err_cnt;
        err_cnt_d    = err_cnt_base;
        if (err_now && (err_cnt_base != {CNT_W{1'b1}})) err_cnt_d = CNT_W'(err_cnt_base + CNT_W'(1));
`endif
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ACQUIRE;
            phase      <= '0;
            phase_oh   <= '0;
            valid      <= 1'b0;
            illegal    <= 1'b0;
            seq_err    <= 1'b0;
            rev_tick   <= 1'b0;
            rev_cnt    <= '0;
            err_sticky <= 1'b0;
`ifdef JOHNSON_MONITOR_ERRCNT_EN
            err_cnt    <= '0;
`endif
        end else begin
            state      <= state_d;
            phase      <= phase_d;
            phase_oh   <= phase_oh_d;
            valid      <= valid_d;
            illegal    <= illegal_d;
            seq_err    <= seq_err_d;
            rev_tick   <= rev_tick_d;
            rev_cnt    <= rev_cnt_d;
            err_sticky <= err_sticky_d;
`ifdef JOHNSON_MONITOR_ERRCNT_EN
            err_cnt    <= err_cnt_d;
`endif
        end
    end

endmodule
